// File: rtl/uart_fifo_tx_pkg.sv
// Shared UART definitions: FSM state encoding, parity codes and bit-period helper.
// Intended to be shared by the transmit side and the planned receive side.
package uart_fifo_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } tx_state_e;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // Clocks per bit, rounded to nearest.
   function automatic int baud_div(input int clk_freq, input int baud);
      return (clk_freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// Show-ahead FIFO read port as seen by the UART transmitter.
// master = transmitter (issues the pop), slave = FIFO (presents head word and flag).
interface uart_fifo_tx_if #(
   parameter int DSIZE = 8
);
   logic [DSIZE-1:0] fifo_rdata;
   logic             fifo_empty;
   logic             fifo_rinc;

   modport master (input fifo_rdata, input fifo_empty, output fifo_rinc);
   modport slave  (output fifo_rdata, output fifo_empty, input fifo_rinc);
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter with synchronous clear.
// tick is high for the single cycle in which the count equals DIV-1.
module uart_baud_tick #(
   parameter int DIV = 434
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int          W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);

   logic [W-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr || tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_fifo_tx.sv
// UART transmitter draining a show-ahead FIFO: pops one word when idle and
// sends start, DSIZE data bits LSB-first, optional parity, then stop bit(s).
module uart_fifo_tx
   import uart_fifo_tx_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD      = 115200,
   parameter int DSIZE     = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_fifo_tx_if.master fifo,
   output logic           txd,
   output logic           busy
);
   localparam int   DIV     = baud_div(CLK_FREQ, BAUD);
   localparam int   BCW     = $clog2(DSIZE + 1);
   localparam bit   PAR_ON  = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
   localparam logic PAR_INV = (PARITY == PAR_ODD);

   localparam logic [BCW-1:0] LAST_DATA = BCW'(DSIZE - 1);
   localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

   tx_state_e        state_q, state_d;
   logic [DSIZE-1:0] shreg_q, shreg_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic             par_q, par_d;
   logic             guard_q;
   logic             txd_q, txd_d;
   logic             pop;
   logic             tick;
   logic             clr;

   // Every state entry restarts the bit period; idle keeps it parked at zero.
   assign clr = (state_d != state_q) || (state_q == ST_IDLE);

   uart_baud_tick #(.DIV(DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .clr  (clr),
      .tick (tick)
   );

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      par_d   = par_q;
      pop     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // guard_q masks the flag for one cycle while the FIFO updates it.
            if (!rst && !fifo.fifo_empty && !guard_q) begin
               pop     = 1'b1;
               shreg_d = fifo.fifo_rdata;
               par_d   = (^fifo.fifo_rdata) ^ PAR_INV;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               bit_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shreg_d = {1'b0, shreg_q[DSIZE-1:1]};
               if (bit_q == LAST_DATA) begin
                  bit_d   = '0;
                  state_d = PAR_ON ? ST_PAR : ST_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_PAR: begin
            if (tick) begin
               bit_d   = '0;
               state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (tick) begin
               if (bit_q == LAST_STOP) begin
                  bit_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level is registered from the next state so txd is glitch-free.
      case (state_d)
         ST_START: txd_d = 1'b0;
         ST_DATA:  txd_d = shreg_d[0];
         ST_PAR:   txd_d = par_d;
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         bit_q   <= '0;
         par_q   <= 1'b0;
         guard_q <= 1'b0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         par_q   <= par_d;
         guard_q <= pop;
         txd_q   <= txd_d;
      end
   end

   assign fifo.fifo_rinc = pop;
   assign busy           = (state_q != ST_IDLE) || pop;
   assign txd            = txd_q;
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Bench for uart_fifo_tx: five parameter variants behind one show-ahead FIFO model,
// each frame compared cycle by cycle against a bit list built from the framing rules.
module tb_uart_fifo_tx;
   localparam int CF [5] = '{50_000_000, 50_000_000, 50_000_000, 50_000_000, 1_000_000};
   localparam int BD [5] = '{115200, 115200, 115200, 115200, 100_000};
   localparam int PA [5] = '{0, 2, 1, 0, 1};
   localparam int SB [5] = '{1, 1, 1, 2, 2};

   logic       clk;
   logic       rst;
   int         sel;
   logic [7:0] rdata_drv;
   logic       empty_drv;
   logic [4:0] txd_a, busy_a, rinc_a;

   logic [7:0] fq[$];
   bit         force_hi;
   int         pop_cnt;
   int         n_total, n_bad;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      uart_fifo_tx_if #(.DSIZE(8)) fif ();
      assign fif.fifo_rdata = rdata_drv;
      assign fif.fifo_empty = (sel == g) ? empty_drv : 1'b1;
      assign rinc_a[g]      = fif.fifo_rinc;
      uart_fifo_tx #(
         .CLK_FREQ (CF[g]),
         .BAUD     (BD[g]),
         .DSIZE    (8),
         .PARITY   (PA[g]),
         .STOP_BITS(SB[g])
      ) dut (
         .clk  (clk),
         .rst  (rst),
         .fifo (fif),
         .txd  (txd_a[g]),
         .busy (busy_a[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void refresh();
      rdata_drv = (fq.size() > 0) ? fq[0] : 8'h00;
      empty_drv = force_hi || (fq.size() == 0);
   endfunction

   task automatic push(input logic [7:0] v);
      fq.push_back(v);
      refresh();
   endtask

   // FIFO side: a pop seen during a cycle retires the head word just after that edge.
   initial begin : fifo_side
      logic seen;
      pop_cnt = 0;
      forever begin
         @(negedge clk);
         #4;
         seen = rinc_a[sel];
         @(posedge clk);
         #1;
         if (seen === 1'b1) begin
            pop_cnt++;
            if (fq.size() > 0) void'(fq.pop_front());
            refresh();
         end
      end
   end

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1, "watchdog");
   end

   // Look for the pop strobe, sampling 1 time unit after each falling edge.
   task automatic wait_pop(input int maxc, input string nm, output int at);
      bit ok;
      ok = 0;
      at = -1;
      for (int c = 0; c < maxc; c++) begin
         #1;
         if (rinc_a[sel] === 1'b1) begin
            ok = 1;
            at = c;
            break;
         end
         @(negedge clk);
      end
      n_total++;
      if (!ok || busy_a[sel] !== 1'b1) begin
         n_bad++;
         $display("FAIL %s: pop_seen=%0d busy=%b, required a pop within %0d cycles with busy=1",
                  nm, ok, busy_a[sel], maxc);
      end
   endtask

   // Called in the pop cycle; walks every cycle of the frame that follows.
   task automatic expect_frame(input int div, input int par, input int stops,
                               input logic [7:0] b, input string nm,
                               output int busy_len, output logic [15:0] mid);
      logic exp_bits[$];
      int   ones, bad, first_at;
      logic first_got, first_exp;
      exp_bits = {};
      exp_bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
      ones = $countones(b);
      if (par == 2) exp_bits.push_back((ones % 2) == 1);
      if (par == 1) exp_bits.push_back((ones % 2) == 0);
      for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
      bad = 0; first_at = -1; first_got = 1'bx; first_exp = 1'bx;
      busy_len = 1;
      mid = '0;
      for (int k = 0; k < exp_bits.size() * div; k++) begin
         @(negedge clk);
         if (busy_a[sel] === 1'b1) busy_len++;
         if (k % div == div / 2) mid[k / div] = txd_a[sel];
         if (txd_a[sel] !== exp_bits[k / div] || rinc_a[sel] !== 1'b0 || busy_a[sel] !== 1'b1) begin
            if (bad == 0) begin
               first_at  = k;
               first_got = txd_a[sel];
               first_exp = exp_bits[k / div];
            end
            bad++;
         end
      end
      n_total++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL %s: %0d bad cycles (first at cycle %0d: txd=%b required %b), required 0",
                  nm, bad, first_at, first_got, first_exp);
      end
   endtask

   task automatic check_idle(input string nm);
      n_total++;
      if (busy_a[sel] !== 1'b0 || txd_a[sel] !== 1'b1 || rinc_a[sel] !== 1'b0) begin
         n_bad++;
         $display("FAIL %s: busy=%b txd=%b rinc=%b, required 0/1/0",
                  nm, busy_a[sel], txd_a[sel], rinc_a[sel]);
      end
   endtask

   task automatic test_reset();
      repeat (4) @(negedge clk);
      n_total++;
      if (txd_a !== 5'h1f) begin n_bad++; $display("FAIL rst_txd: got %b required 11111", txd_a); end
      n_total++;
      if (busy_a !== 5'h00) begin n_bad++; $display("FAIL rst_busy: got %b required 00000", busy_a); end
      n_total++;
      if (rinc_a !== 5'h00) begin n_bad++; $display("FAIL rst_rinc: got %b required 00000", rinc_a); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("post_rst_idle");
   endtask

   task automatic test_single();
      int p0, at, bl;
      logic [15:0] mid;
      sel = 0;
      p0 = pop_cnt;
      push(8'h55);
      wait_pop(3, "t1_pop", at);
      expect_frame(434, 0, 1, 8'h55, "t1_frame", bl, mid);
      n_total++;
      if (mid[9:0] !== 10'b1010101010) begin
         n_bad++; $display("FAIL t1_bits: got %b required 1010101010", mid[9:0]);
      end
      n_total++;
      if (bl !== 4341) begin n_bad++; $display("FAIL t1_busy_len: got %0d required 4341", bl); end
      @(negedge clk);
      check_idle("t1_after");
      repeat (10) @(negedge clk);
      n_total++;
      if (pop_cnt - p0 !== 1) begin n_bad++; $display("FAIL t1_pops: got %0d required 1", pop_cnt - p0); end
   endtask

   task automatic test_back_to_back();
      int p0, at, bl;
      logic [15:0] mid;
      sel = 0;
      p0 = pop_cnt;
      push(8'hA3);
      push(8'h0F);
      wait_pop(3, "t2_pop0", at);
      expect_frame(434, 0, 1, 8'hA3, "t2_frame0", bl, mid);
      wait_pop(3, "t2_pop1", at);
      n_total++;
      if (at !== 1) begin n_bad++; $display("FAIL t2_gap: pop %0d cycles after stop end, required 1", at); end
      expect_frame(434, 0, 1, 8'h0F, "t2_frame1", bl, mid);
      @(negedge clk);
      check_idle("t2_after");
      n_total++;
      if (pop_cnt - p0 !== 2) begin n_bad++; $display("FAIL t2_pops: got %0d required 2", pop_cnt - p0); end
   endtask

   task automatic test_parity();
      int at, bl, pm;
      logic [15:0] mid;
      for (int k = 0; k < 2; k++) begin
         sel = (k == 0) ? 1 : 2;
         pm  = (k == 0) ? 2 : 1;
         push(8'h07);
         wait_pop(3, "par_pop", at);
         expect_frame(434, pm, 1, 8'h07, "par_frame", bl, mid);
         n_total++;
         if (mid[9] !== ((k == 0) ? 1'b1 : 1'b0)) begin
            n_bad++; $display("FAIL par_bit mode=%0d: got %b required %b", pm, mid[9], (k == 0));
         end
         @(negedge clk);
         check_idle("par_after");
      end
   endtask

   task automatic test_stop2();
      int at, bl;
      logic [15:0] mid;
      logic [7:0] b2;
      sel = 3;
      b2 = 8'($urandom);
      push(8'hFF);
      push(b2);
      wait_pop(3, "stop2_pop0", at);
      expect_frame(434, 0, 2, 8'hFF, "stop2_frame0", bl, mid);
      n_total++;
      if (mid[10:9] !== 2'b11) begin n_bad++; $display("FAIL stop2_bits: got %b required 11", mid[10:9]); end
      wait_pop(3, "stop2_pop1", at);
      n_total++;
      if (at !== 1) begin n_bad++; $display("FAIL stop2_gap: pop %0d cycles after stop end, required 1", at); end
      expect_frame(434, 0, 2, b2, "stop2_frame1", bl, mid);
      @(negedge clk);
      check_idle("stop2_after");
   endtask

   task automatic test_reset_midframe();
      int at, bl;
      logic [15:0] mid;
      logic [7:0] b, c;
      sel = 0;
      b = 8'($urandom);
      c = 8'($urandom);
      push(b);
      push(c);
      wait_pop(3, "rm_pop0", at);
      repeat (5 * 434 + 200) @(negedge clk);
      n_total++;
      if (txd_a[0] !== b[4]) begin n_bad++; $display("FAIL rm_bit4: got %b required %b", txd_a[0], b[4]); end
      rst = 1'b1;
      @(negedge clk);
      check_idle("rm_in_reset");
      rst = 1'b0;
      wait_pop(3, "rm_pop1", at);
      n_total++;
      if (at !== 0) begin n_bad++; $display("FAIL rm_repop: pop %0d cycles after release, required 0", at); end
      expect_frame(434, 0, 1, c, "rm_frame", bl, mid);
      @(negedge clk);
      check_idle("rm_after");
   endtask

   task automatic test_empty_hold();
      int p0, bad, bl;
      logic [15:0] mid;
      logic [7:0] d;
      sel = 0;
      d = 8'($urandom);
      force_hi = 1'b1;
      push(d);
      p0 = pop_cnt;
      bad = 0;
      repeat (10000) begin
         @(negedge clk);
         if (txd_a[0] !== 1'b1 || rinc_a[0] !== 1'b0) bad++;
      end
      n_total++;
      if (bad !== 0) begin n_bad++; $display("FAIL hold_quiet: %0d active cycles, required 0", bad); end
      force_hi = 1'b0;
      refresh();
      #1;
      n_total++;
      if (rinc_a[0] !== 1'b1) begin n_bad++; $display("FAIL hold_pop: rinc=%b required 1", rinc_a[0]); end
      expect_frame(434, 0, 1, d, "hold_frame", bl, mid);
      @(negedge clk);
      check_idle("hold_after");
      repeat (20) @(negedge clk);
      n_total++;
      if (pop_cnt - p0 !== 1) begin n_bad++; $display("FAIL hold_pops: got %0d required 1", pop_cnt - p0); end
   endtask

   task automatic test_random_stream();
      int n, at, bl;
      logic [15:0] mid;
      logic [7:0] v;
      logic [7:0] expq[$];
      sel = 4;
      for (int r = 0; r < 14; r++) begin
         n = $urandom_range(1, 3);
         for (int i = 0; i < n; i++) begin
            v = 8'($urandom);
            push(v);
            expq.push_back(v);
         end
         for (int i = 0; i < n; i++) begin
            wait_pop(3, "rand_pop", at);
            if (i > 0) begin
               n_total++;
               if (at !== 1) begin n_bad++; $display("FAIL rand_gap: pop %0d cycles after stop end, required 1", at); end
            end
            expect_frame(10, 1, 2, expq.pop_front(), "rand_frame", bl, mid);
            if (i == n - 1) begin
               n_total++;
               if (bl !== 1 + 12 * 10) begin n_bad++; $display("FAIL rand_busy_len: got %0d required 121", bl); end
            end
         end
         @(negedge clk);
         check_idle("rand_idle");
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
   endtask

   initial begin
      n_total  = 0;
      n_bad    = 0;
      rst      = 1'b1;
      sel      = 0;
      force_hi = 1'b0;
      refresh();
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_stop2();
      test_reset_midframe();
      test_empty_hold();
      test_random_stream();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
